// File: rtl/vga_canvas.sv
// VGA timing plus a cell-bitmap drawing canvas with a cursor box.
// The bitmap is painted at the end of the active region and can be cleared one row per clock.
module vga_canvas #(
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int H_ACT      = 800,
  parameter int H_FP       = 40,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter int V_ACT      = 600,
  parameter int V_FP       = 1,
  parameter int GRID_W     = 32,
  parameter int GRID_H     = 32,
  parameter int CELL_SHIFT = 4,
  parameter int CUR_W      = 8,
  parameter int CUR_H      = 16,
  parameter int BRUSH_R    = 1
) (
  input  logic                       clkVga,
  input  logic                       iRstN,
  input  logic [10:0]                iCurX,
  input  logic [10:0]                iCurY,
  input  logic                       iDraw,
  input  logic                       iErase,
  input  logic                       iClear,
  output logic [3:0]                 oRed,
  output logic [3:0]                 oGreen,
  output logic [3:0]                 oBlue,
  output logic                       oHs,
  output logic                       oVs,
  output logic                       oFrame,
  output logic                       oBusy,
  output logic [GRID_W*GRID_H-1:0]   oImage
);

  localparam int N    = GRID_W * GRID_H;
  localparam int IDXW = $clog2(N);
  localparam int RW   = $clog2(GRID_H);

  localparam logic [11:0] H_LAST  = 12'(H_SYNC + H_BP + H_ACT + H_FP - 1);
  localparam logic [11:0] V_LAST  = 12'(V_SYNC + V_BP + V_ACT + V_FP - 1);
  localparam logic [11:0] H_A0    = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_A1    = 12'(H_SYNC + H_BP + H_ACT);
  localparam logic [11:0] V_A0    = 12'(V_SYNC + V_BP);
  localparam logic [11:0] V_A1    = 12'(V_SYNC + V_BP + V_ACT);
  localparam logic [11:0] V_LATCH = 12'(V_SYNC + V_BP + V_ACT);
  localparam logic [11:0] H_SY    = 12'(H_SYNC);
  localparam logic [11:0] V_SY    = 12'(V_SYNC);
  localparam logic [11:0] GPX_W   = 12'(GRID_W << CELL_SHIFT);
  localparam logic [11:0] GPX_H   = 12'(GRID_H << CELL_SHIFT);
  localparam logic [RW-1:0] ROW_LAST = RW'(GRID_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_PAINT, S_CLEAR} state_e;

  function automatic logic [IDXW-1:0] cellIdx(input int r, input int c);
    return IDXW'(r * GRID_W + c);
  endfunction

  logic [11:0]   hCnt_q, vCnt_q;
  logic [3:0]    red_q, green_q, blue_q;
  logic [3:0]    red_d, green_d, blue_d;
  logic          hs_q, vs_q, frame_q, busy_q;
  logic [N-1:0]  img_q;
  state_e        state_q;
  logic [RW-1:0] rowIdx_q;
  logic [10:0]   col_q, row_q;
  logic          val_q;

  logic [11:0] hPos, vPos, curX, curY;
  logic        active, inBox, inGrid, latchPt, curInGrid;
  logic [10:0] curCol, curRow;

  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      hCnt_q <= '0;
      vCnt_q <= '0;
    end else if (hCnt_q == H_LAST) begin
      hCnt_q <= '0;
      vCnt_q <= (vCnt_q == V_LAST) ? 12'd0 : vCnt_q + 12'd1;
    end else begin
      hCnt_q <= hCnt_q + 12'd1;
    end
  end

  assign hPos   = hCnt_q - H_A0;
  assign vPos   = vCnt_q - V_A0;
  assign curX   = {1'b0, iCurX};
  assign curY   = {1'b0, iCurY};
  assign active = (hCnt_q >= H_A0) && (hCnt_q < H_A1) && (vCnt_q >= V_A0) && (vCnt_q < V_A1);
  // Box edges are inclusive on both sides, so it spans CUR_W+1 by CUR_H+1 pixels.
  assign inBox  = (hPos >= curX) && (hPos <= curX + 12'(CUR_W)) &&
                  (vPos >= curY) && (vPos <= curY + 12'(CUR_H));
  assign inGrid = (hPos < GPX_W) && (vPos < GPX_H);

  always_comb begin
    red_d   = 4'h0;
    green_d = 4'h0;
    blue_d  = 4'h0;
    if (active) begin
      if (inBox) begin
        if (iDraw)       green_d = 4'hF;
        else if (iErase) blue_d  = 4'hF;
        else             red_d   = 4'hF;
      end else if (inGrid) begin
        if (img_q[cellIdx(int'(vPos >> CELL_SHIFT), int'(hPos >> CELL_SHIFT))]) begin
          red_d  = 4'hF;
          blue_d = 4'hF;
        end else begin
          red_d   = 4'h8;
          green_d = 4'h8;
          blue_d  = 4'h8;
        end
      end else begin
        red_d   = 4'h2;
        green_d = 4'h2;
        blue_d  = 4'h2;
      end
    end
  end

  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hs_q    <= !(hCnt_q < H_SY);
      vs_q    <= !(vCnt_q < V_SY);
      frame_q <= (hCnt_q == 12'd0) && (vCnt_q == 12'd0);
    end
  end

  assign latchPt   = (vCnt_q == V_LATCH) && (hCnt_q == 12'd0);
  assign curCol    = iCurX >> CELL_SHIFT;
  assign curRow    = iCurY >> CELL_SHIFT;
  assign curInGrid = (int'(curCol) < GRID_W) && (int'(curRow) < GRID_H);

  // Paint is latched in vertical blanking so the visible bitmap never tears.
  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      state_q  <= S_IDLE;
      rowIdx_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      val_q    <= 1'b0;
      busy_q   <= 1'b0;
      img_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iClear) begin
            state_q  <= S_CLEAR;
            rowIdx_q <= '0;
            busy_q   <= 1'b1;
          end else if (latchPt && (iDraw || iErase) && curInGrid) begin
            state_q <= S_PAINT;
            col_q   <= curCol;
            row_q   <= curRow;
            val_q   <= iDraw;
          end
        end
        S_PAINT: begin
          img_q[cellIdx(int'(row_q), int'(col_q))] <= val_q;
          if (BRUSH_R >= 1) begin
            if (row_q != 11'd0)              img_q[cellIdx(int'(row_q) - 1, int'(col_q))] <= val_q;
            if (int'(row_q) < GRID_H - 1)    img_q[cellIdx(int'(row_q) + 1, int'(col_q))] <= val_q;
            if (col_q != 11'd0)              img_q[cellIdx(int'(row_q), int'(col_q) - 1)] <= val_q;
            if (int'(col_q) < GRID_W - 1)    img_q[cellIdx(int'(row_q), int'(col_q) + 1)] <= val_q;
          end
          if (iClear) begin
            state_q  <= S_CLEAR;
            rowIdx_q <= '0;
            busy_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_CLEAR: begin
          for (int cc = 0; cc < GRID_W; cc++) img_q[cellIdx(int'(rowIdx_q), cc)] <= 1'b0;
          if (rowIdx_q == ROW_LAST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            rowIdx_q <= rowIdx_q + RW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oRed   = red_q;
  assign oGreen = green_q;
  assign oBlue  = blue_q;
  assign oHs    = hs_q;
  assign oVs    = vs_q;
  assign oFrame = frame_q;
  assign oBusy  = busy_q;
  assign oImage = img_q;

endmodule

// File: tb/tb_vga_canvas.sv
// Scoreboard bench for vga_canvas on a shrunken timing/grid so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_canvas;
  localparam int HS = 2, HB = 3, HA = 20, HF = 2;
  localparam int VS = 2, VB = 2, VA = 20, VF = 1;
  localparam int GW = 8, GH = 8, CS = 1, CW = 3, CH = 4, BR = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;
  localparam int CELL = 1 << CS;
  localparam int N = GW * GH;
  localparam int LATCH = (VS + VB + VA) * HT;

  logic clk = 1'b0;
  logic iRstN;
  logic [10:0] iCurX, iCurY;
  logic iDraw, iErase, iClear;
  logic [3:0] oRed, oGreen, oBlue;
  logic oHs, oVs, oFrame, oBusy;
  logic [N-1:0] oImage;

  vga_canvas #(
    .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF),
    .GRID_W(GW), .GRID_H(GH), .CELL_SHIFT(CS),
    .CUR_W(CW), .CUR_H(CH), .BRUSH_R(BR)
  ) dut (
    .clkVga(clk), .iRstN(iRstN), .iCurX(iCurX), .iCurY(iCurY),
    .iDraw(iDraw), .iErase(iErase), .iClear(iClear),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oHs(oHs), .oVs(oVs),
    .oFrame(oFrame), .oBusy(oBusy), .oImage(oImage)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0]  rgb;
    logic [2:0]   syn;
    logic         busy;
    logic [N-1:0] img;
  } exp_t;

  exp_t q[$];
  int nChk = 0, nPass = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: position is just cycle count modulo the frame; bitmap edits are events.
  int cyc;
  logic [N-1:0] mimg;
  bit clrOn, pend, pVal;
  int clrRow, pRow, pCol;

  task automatic brush(input int r, input int c, input bit v);
    for (int dr = -BR; dr <= BR; dr++)
      for (int dc = -BR; dc <= BR; dc++) begin
        int ar, ac;
        ar = dr < 0 ? -dr : dr;
        ac = dc < 0 ? -dc : dc;
        if (ar + ac <= BR && r + dr >= 0 && r + dr < GH && c + dc >= 0 && c + dc < GW)
          mimg[(r + dr) * GW + (c + dc)] = v;
      end
  endtask

  always @(posedge clk) begin
    int p, hc, vc, hp, vp, cx, cy;
    exp_t e;
    if (!iRstN) begin
      cyc = 0; mimg = '0; clrOn = 0; pend = 0; q.delete();
    end else begin
      p = cyc % FT; hc = p % HT; vc = p / HT;
      hp = hc - (HS + HB); vp = vc - (VS + VB);
      cx = int'(iCurX); cy = int'(iCurY);
      e = '0;
      e.syn = {hc >= HS, vc >= VS, p == 0};
      if (hp >= 0 && hp < HA && vp >= 0 && vp < VA) begin
        if (hp >= cx && hp <= cx + CW && vp >= cy && vp <= cy + CH)
          e.rgb = iDraw ? 12'h0F0 : (iErase ? 12'h00F : 12'hF00);
        else if (hp < GW * CELL && vp < GH * CELL)
          e.rgb = mimg[(vp / CELL) * GW + hp / CELL] ? 12'hF0F : 12'h888;
        else
          e.rgb = 12'h222;
      end
      if (clrOn) begin
        mimg[clrRow * GW +: GW] = '0;
        clrRow++;
        if (clrRow == GH) clrOn = 0;
      end else begin
        if (pend) begin
          brush(pRow, pCol, pVal);
          pend = 0;
        end else if (!iClear && p == LATCH && (iDraw || iErase) && cx / CELL < GW && cy / CELL < GH) begin
          pend = 1; pRow = cy / CELL; pCol = cx / CELL; pVal = iDraw;
        end
        if (iClear) begin clrOn = 1; clrRow = 0; end
      end
      e.busy = clrOn;
      e.img = mimg;
      q.push_back(e);
      cyc++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (iRstN && q.size() > 0) begin
      e = q.pop_front();
      check("rgb", N'(oRed), N'(e.rgb[11:8]));
      check("green_blue", N'({oGreen, oBlue}), N'(e.rgb[7:0]));
      check("hs_vs_frame", N'({oHs, oVs, oFrame}), N'(e.syn));
      check("busy", N'(oBusy), N'(e.busy));
      check("image", oImage, e.img);
      if (nChk - nPass > 30) begin
        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
      end
    end
  end

  task automatic frames(input int n);
    repeat (n * FT) @(negedge clk);
  endtask

  // Returns at a negedge where the next sampling edge has frame position p.
  task automatic wait_pos(input int p);
    int k = 0;
    @(negedge clk);
    while ((cyc % FT) != p && k < FT + 4) begin @(negedge clk); k++; end
    if (k >= FT + 4) check("wait_pos_timeout", N'(k), N'(0));
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rgb"}, N'({oRed, oGreen, oBlue}), N'(0));
    check({tag, "_sync"}, N'({oHs, oVs, oFrame, oBusy}), N'(4'b1100));
    check({tag, "_img"}, oImage, N'(0));
  endtask

  function automatic logic [N-1:0] plus(input int r, input int c);
    logic [N-1:0] m = '0;
    m[r * GW + c] = 1'b1;
    if (r > 0) m[(r - 1) * GW + c] = 1'b1;
    if (r < GH - 1) m[(r + 1) * GW + c] = 1'b1;
    if (c > 0) m[r * GW + c - 1] = 1'b1;
    if (c < GW - 1) m[r * GW + c + 1] = 1'b1;
    return m;
  endfunction

  initial begin
    int cnt, fper;
    logic [N-1:0] corner;
    iRstN = 1'b0; iCurX = 11'd100; iCurY = 11'd100;
    iDraw = 0; iErase = 0; iClear = 0;
    #23;
    reset_checks("reset");
    @(negedge clk); #2 iRstN = 1'b1;

    // Free run; frame period measured directly too.
    while (!oFrame) @(negedge clk);
    fper = 0;
    do begin @(negedge clk); fper++; end while (!oFrame && fper < 2 * FT);
    check("frame_period", N'(fper), N'(FT));
    frames(1);

    // Plus brush at cell (2,2).
    iCurX = 11'd5; iCurY = 11'd5; iDraw = 1;
    frames(1);
    iDraw = 0;
    check("draw_plus", oImage, plus(2, 2));

    // Corner cell (0, GH-1): clipped, no wrap.
    iCurX = 11'd0; iCurY = 11'(CELL * (GH - 1));
    iDraw = 1; frames(1); iDraw = 0;
    corner = '0;
    corner[(GH - 1) * GW] = 1'b1; corner[(GH - 2) * GW] = 1'b1; corner[(GH - 1) * GW + 1] = 1'b1;
    check("corner_clip", oImage, plus(2, 2) | corner);

    iCurX = 11'd5; iCurY = 11'd5;
    iErase = 1; frames(1); iErase = 0;
    check("erase", oImage, corner);
    iDraw = 1; iErase = 1; frames(1); iDraw = 0; iErase = 0;
    check("draw_wins", oImage, plus(2, 2) | corner);

    // Random cursor moves and modes, including off-grid positions.
    repeat (8 * FT / 45) begin
      iCurX = 11'($urandom_range(0, 24));
      iCurY = 11'($urandom_range(0, 24));
      iDraw = ($urandom_range(0, 3) != 0);
      iErase = ($urandom_range(0, 2) == 0);
      repeat (45) @(negedge clk);
    end
    iDraw = 0; iErase = 0;

    // Clear length, with a second pulse mid-clear that must be ignored.
    @(negedge clk) iClear = 1;
    @(negedge clk) iClear = 0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (oBusy) cnt++;
      iClear = (i == 3);
      @(negedge clk);
    end
    iClear = 0;
    check("busy_len", N'(cnt), N'(GH));
    check("clear_img", oImage, N'(0));

    // Paint latch falling inside a clear is skipped.
    iCurX = 11'd5; iCurY = 11'd5; iDraw = 1;
    wait_pos(LATCH - 3);
    iClear = 1; @(negedge clk); iClear = 0;
    repeat (20) @(negedge clk);
    iDraw = 0;
    check("latch_in_clear", oImage, N'(0));

    // Clear on the latch clock itself beats the paint.
    iDraw = 1;
    wait_pos(LATCH);
    iClear = 1; @(negedge clk); iClear = 0;
    repeat (20) @(negedge clk);
    iDraw = 0;
    check("clear_beats_paint", oImage, N'(0));

    // Paint, then reset in the middle of a clear and a line.
    iDraw = 1; frames(1); iDraw = 0;
    wait_pos(5 * HT + 10);
    iClear = 1; @(negedge clk); iClear = 0;
    repeat (3) @(negedge clk);
    #2 iRstN = 1'b0;
    #1 reset_checks("async_reset");
    @(negedge clk); #2 iRstN = 1'b1;

    // Cursor box colours follow mode changes mid-frame.
    iCurX = 11'd8; iCurY = 11'd8;
    repeat (3) begin
      iDraw = 1; iErase = 0; repeat (FT / 3) @(negedge clk);
      iDraw = 0; iErase = 1; repeat (FT / 3) @(negedge clk);
      iErase = 0; repeat (FT / 3) @(negedge clk);
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
